// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter
//
// Shares the single instruction/data memory port of the Tinker core between
// the fetch stage and the data (load/store/call/return) stage. Only one
// transaction is outstanding at a time. Data wins over fetch, except that
// fetch is forced through after STARVE_LIMIT consecutive data grants while
// it was waiting. Read data comes back MEM_LATENCY cycles after the grant,
// and a branch flush can squash a fetch that is still in flight.
//
// Parameters
//   MEM_LATENCY   cycles from read issue to mem_rdata valid (1..15)
//   STARVE_LIMIT  data grants tolerated while fetch waits (1..15)
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr/if_flush    fetch request, address, squash
//   if_gnt/if_rvalid/if_rdata  fetch grant, response pulse, instruction
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_gnt/d_rvalid/d_rdata     data grant, load response pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory port
//   busy                       a read is in flight or responding

module tinker_mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT      state;
    logic [3:0] latCnt;
    logic [3:0] starveCnt;
    logic       ownerFetch;
    logic       squash;

    logic       canGrant;
    logic       starved;
    logic       fetchEligible;
    logic       ifGntInt;
    logic       dGntInt;
    logic       readGnt;
    logic       respActive;

    // Grants are only possible in IDLE and never while reset is held, so
    // every output collapses to zero the moment reset goes low. A flush in
    // the grant cycle keeps fetch out of arbitration entirely, which lets a
    // pending data request win even when fetch is nominally starved.
    assign canGrant      = reset & (state == IDLE);
    assign starved       = (starveCnt == 4'(STARVE_LIMIT));
    assign fetchEligible = if_req & ~if_flush;
    assign dGntInt       = canGrant & d_req & ~(fetchEligible & starved);
    assign ifGntInt      = canGrant & fetchEligible & (~d_req | starved);
    assign readGnt       = ifGntInt | (dGntInt & ~d_we);

    assign if_gnt = ifGntInt;
    assign d_gnt  = dGntInt;

    // The memory port is driven only during the grant cycle, muxed from
    // whichever requester won; fetch never writes.
    always_comb begin
        mem_en    = ifGntInt | dGntInt;
        mem_we    = dGntInt & d_we;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (ifGntInt) begin
            mem_addr = if_addr;
        end else if (dGntInt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Responses are steered by the owner latched at grant. A flush arriving
    // in the response cycle itself still suppresses the fetch pulse, so the
    // squash flag is bypassed combinationally here.
    assign respActive = reset & (state == RESP);
    assign if_rvalid  = respActive & ownerFetch & ~squash & ~if_flush;
    assign d_rvalid   = respActive & ~ownerFetch;
    assign if_rdata   = if_rvalid ? mem_rdata[31:0] : 32'd0;
    assign d_rdata    = d_rvalid ? mem_rdata : 64'd0;

    // Transaction FSM. Stores complete in the grant cycle and never leave
    // IDLE; reads wait out the memory latency and then spend one cycle in
    // RESP. busy is kept as a flop that mirrors "next state is not IDLE" so
    // it comes straight off a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            latCnt     <= 4'd0;
            ownerFetch <= 1'b0;
            squash     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    if (readGnt) begin
                        ownerFetch <= ifGntInt;
                        busy       <= 1'b1;
                        if (MEM_LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state  <= WAIT;
                            latCnt <= 4'(MEM_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (if_flush && ownerFetch) begin
                        squash <= 1'b1;
                    end
                    if (latCnt == 4'd1) begin
                        state  <= RESP;
                        latCnt <= 4'd0;
                    end else begin
                        latCnt <= latCnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    squash <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts data grants that happened while fetch was
    // asking, saturating at 15. A fetch grant, or an IDLE cycle in which
    // fetch is not asking, wipes the history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= 4'd0;
        end else if (ifGntInt) begin
            starveCnt <= 4'd0;
        end else if (dGntInt && if_req) begin
            if (starveCnt != 4'hF) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end else if (canGrant && !if_req) begin
            starveCnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter
//
// Directed scoreboard bench for tinker_mem_arbiter (MEM_LATENCY=2,
// STARVE_LIMIT=4). Stimulus pushes the hand-computed grants and responses
// into a queue; a monitor on the falling edge pops one entry for every
// grant or rvalid the arbiter shows and compares cycle and payload. A small
// memory model returns read data MEM_LATENCY cycles after a read strobe.

module tb_tinker_mem_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 4;

    localparam int KDG = 0;
    localparam int KIG = 1;
    localparam int KDR = 2;
    localparam int KIR = 3;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        busy;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic [63:0] rdata;
    } expT;

    expT         expQ[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [63:0] rdPipe[LAT];

    tinker_mem_arbiter #(
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: one fixed word for the single-fetch vector, an
    // address-derived pattern elsewhere.
    function automatic logic [63:0] memWord(input logic [63:0] a);
        if (a == 64'h2000) return 64'h1234_5678_8800_0000;
        return {a[31:0] ^ 32'hA5A5_A5A5, ~a[31:0]};
    endfunction

    // Memory latency model; non-read cycles shift in junk so ungated rdata
    // outputs show up.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rdPipe[i] <= rdPipe[i-1];
        rdPipe[0] <= (mem_en && !mem_we) ? memWord(mem_addr) : 64'hFEED_FACE_0BAD_F00D;
    end
    assign mem_rdata = rdPipe[LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushGrant(input int kind, input int c, input logic [63:0] a,
                             input logic [63:0] wd, input logic we);
        expT e;
        e.kind = kind; e.cyc = c; e.addr = a; e.wdata = wd; e.we = we; e.rdata = 64'd0;
        expQ.push_back(e);
    endtask

    task automatic pushResp(input int kind, input int c, input logic [63:0] rd);
        expT e;
        e.kind = kind; e.cyc = c; e.addr = 64'd0; e.wdata = 64'd0; e.we = 1'b0; e.rdata = rd;
        expQ.push_back(e);
    endtask

    task automatic handleEvent(input int kind, input logic [63:0] rd);
        expT e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedEvent: got kind %0d at cycle %0d expected none", kind, cyc);
            return;
        end
        e = expQ.pop_front();
        checkOutput("eventKind", 64'(kind), 64'(e.kind));
        checkOutput("eventCycle", 64'(cyc), 64'(e.cyc));
        if (kind <= KIG) begin
            checkOutput("memEn", 64'(mem_en), 64'd1);
            checkOutput("memWe", 64'(mem_we), 64'(e.we));
            checkOutput("memAddr", mem_addr, e.addr);
            checkOutput("memWdata", mem_wdata, e.wdata);
        end else begin
            checkOutput("rdata", rd, e.rdata);
        end
    endtask

    // Monitor: every visible grant or response consumes one scoreboard
    // entry; quiet cycles must leave the memory port and rdata at zero.
    always @(negedge clk) begin
        if (d_gnt)     handleEvent(KDG, 64'd0);
        if (if_gnt)    handleEvent(KIG, 64'd0);
        if (d_rvalid)  handleEvent(KDR, d_rdata);
        if (if_rvalid) handleEvent(KIR, {32'd0, if_rdata});
        if (!d_gnt && !if_gnt)
            checkOutput("memIdle", {mem_en, mem_we, 62'd0} | mem_addr | mem_wdata, 64'd0);
        if (!d_rvalid)  checkOutput("dRdataGated", d_rdata, 64'd0);
        if (!if_rvalid) checkOutput("ifRdataGated", {32'd0, if_rdata}, 64'd0);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus;
        int          c0;
        logic [63:0] w;

        // Reset state with both requesters asking
        reset = 1'b0; if_req = 1'b1; if_addr = 64'h10; if_flush = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h20; d_wdata = 64'd0;
        step(1);
        @(negedge clk);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetGnts", 64'({if_gnt, d_gnt}), 64'd0);
        step(1);
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        step(2);

        // Single fetch
        c0 = cyc;
        if_req = 1'b1; if_addr = 64'h2000;
        w = memWord(64'h2000);
        pushGrant(KIG, c0, 64'h2000, 64'd0, 1'b0);
        pushResp(KIR, c0 + 2, {32'd0, w[31:0]});
        @(negedge clk); checkOutput("busyAtGrant", 64'(busy), 64'd0);
        step(1); if_req = 1'b0;
        @(negedge clk); checkOutput("busyWait", 64'(busy), 64'd1);
        step(1);
        @(negedge clk); checkOutput("busyResp", 64'(busy), 64'd1);
        step(1);
        @(negedge clk); checkOutput("busyDone", 64'(busy), 64'd0);
        step(2);

        // Contention: data load wins, fetch follows after the response
        c0 = cyc;
        if_req = 1'b1; if_addr = 64'h3000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h1000; d_wdata = 64'd0;
        pushGrant(KDG, c0, 64'h1000, 64'd0, 1'b0);
        pushResp(KDR, c0 + 2, memWord(64'h1000));
        w = memWord(64'h3000);
        pushGrant(KIG, c0 + 3, 64'h3000, 64'd0, 1'b0);
        pushResp(KIR, c0 + 5, {32'd0, w[31:0]});
        step(1); d_req = 1'b0;
        step(3); if_req = 1'b0;
        step(3);

        // Starvation: four stores, forced fetch, held store resumes at 5+LAT
        c0 = cyc;
        if_req = 1'b1; if_addr = 64'h4000;
        d_req = 1'b1; d_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_addr = 64'h100 + 64'(8 * i); d_wdata = 64'hA000_0000_0000_0000 + 64'(i);
            pushGrant(KDG, c0 + i, d_addr, d_wdata, 1'b1);
            step(1);
        end
        d_addr = 64'h120; d_wdata = 64'hA000_0000_0000_0004;
        w = memWord(64'h4000);
        pushGrant(KIG, c0 + 4, 64'h4000, 64'd0, 1'b0);
        pushResp(KIR, c0 + 4 + LAT, {32'd0, w[31:0]});
        pushGrant(KDG, c0 + 5 + LAT, 64'h120, 64'hA000_0000_0000_0004, 1'b1);
        step(1); if_req = 1'b0;
        step(3); d_req = 1'b0;
        step(2);

        // Back-to-back stores
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80000; d_wdata = 64'hDEAD_BEEF;
        pushGrant(KDG, c0, 64'h80000, 64'hDEAD_BEEF, 1'b1);
        step(1);
        d_addr = 64'h80008; d_wdata = 64'hCAFE_F00D;
        pushGrant(KDG, c0 + 1, 64'h80008, 64'hCAFE_F00D, 1'b1);
        @(negedge clk); checkOutput("busyStore", 64'(busy), 64'd0);
        step(1); d_req = 1'b0; d_we = 1'b0; d_wdata = 64'd0;
        step(3);

        // Flush while the fetch waits: no response, load granted at T+3
        c0 = cyc;
        if_req = 1'b1; if_addr = 64'h5000;
        pushGrant(KIG, c0, 64'h5000, 64'd0, 1'b0);
        step(1); if_req = 1'b0; if_flush = 1'b1;
        step(1); if_flush = 1'b0;
        step(1);
        d_req = 1'b1; d_addr = 64'h6000;
        pushGrant(KDG, c0 + 3, 64'h6000, 64'd0, 1'b0);
        pushResp(KDR, c0 + 5, memWord(64'h6000));
        step(1); d_req = 1'b0;
        step(3);

        // Flush in the response cycle itself
        c0 = cyc;
        if_req = 1'b1; if_addr = 64'h5100;
        pushGrant(KIG, c0, 64'h5100, 64'd0, 1'b0);
        step(1); if_req = 1'b0;
        step(1); if_flush = 1'b1;
        step(1); if_flush = 1'b0;
        step(2);

        // Flush in IDLE blocks the fetch grant for that cycle only
        c0 = cyc;
        if_req = 1'b1; if_addr = 64'h5200; if_flush = 1'b1;
        w = memWord(64'h5200);
        pushGrant(KIG, c0 + 1, 64'h5200, 64'd0, 1'b0);
        pushResp(KIR, c0 + 3, {32'd0, w[31:0]});
        step(1); if_flush = 1'b0;
        step(1); if_req = 1'b0;
        step(3);

        // Reset in the middle of a load
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h7000;
        pushGrant(KDG, c0, 64'h7000, 64'd0, 1'b0);
        step(1);
        if_req = 1'b1; if_addr = 64'h7100; reset = 1'b0;
        #1;
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        checkOutput("midResetGnts", 64'({if_gnt, d_gnt, mem_en}), 64'd0);
        checkOutput("midResetAddr", mem_addr, 64'd0);
        step(2);
        reset = 1'b1; d_req = 1'b0;
        w = memWord(64'h7100);
        pushGrant(KIG, c0 + 3, 64'h7100, 64'd0, 1'b0);
        pushResp(KIR, c0 + 5, {32'd0, w[31:0]});
        step(1); if_req = 1'b0;
        step(4);
    endtask

    initial begin
        applyStimulus();
        @(negedge clk);
        checkOutput("pendingExpected", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tinker_mem_arbiter.md
# tinker_mem_arbiter

Arbitrates the single shared instruction/data memory port of the Tinker core between the fetch stage and the data (load/store/call/return) stage. One transaction is outstanding at a time. Arbitration is fixed-priority data-over-fetch, with a starvation guard for fetch. Read responses are returned after a parameterised memory latency, and an in-flight fetch can be squashed on a branch flush.

## Interface
- MEM_LATENCY, 2: cycles from read issue to `mem_rdata` valid; legal range 1..15.
- STARVE_LIMIT, 4: consecutive data grants allowed while `if_req` is pending before fetch is forced; legal range 1..15.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- if_req  in  1  fetch request; held with `if_addr` until `if_gnt`.
- if_addr  in  64  fetch byte address.
- if_flush  in  1  squash any pending or in-flight fetch response.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; `if_rdata` is valid.
- if_rdata  out  32  instruction word, equal to `mem_rdata[31:0]`.
- d_req  in  1  data request; held with `d_we`, `d_addr`, `d_wdata` until `d_gnt`.
- d_we  in  1  1 = store (8 bytes), 0 = load.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; `d_rdata` is valid (loads only).
- d_rdata  out  64  load data, equal to `mem_rdata`.
- mem_en  out  1  memory access strobe, asserted in the grant cycle.
- mem_we  out  1  write strobe, qualified by `mem_en`.
- mem_addr  out  64  address, driven in the grant cycle.
- mem_wdata  out  64  write data, driven in the grant cycle.
- mem_rdata  in  64  read data, valid MEM_LATENCY cycles after a read `mem_en`.
- busy  out  1  arbiter is not IDLE.

## Operation
- FSM states:
  - IDLE: may grant.
  - WAIT: a read is in flight; a 4-bit latency counter is running.
  - RESP: response cycle.
- IDLE arbitration (combinational, grant cycle T):
  - No request: no grant.
  - Only one requester active: grant that requester.
  - Both active: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
- Memory port in the grant cycle:
  - `mem_en = if_gnt | d_gnt`.
  - `mem_addr` and `mem_wdata` are muxed from the granted requester.
  - `mem_we = d_gnt & d_we`.
  - Outside the grant cycle, all `mem_*` outputs are 0.
- Store grant: the FSM stays in IDLE. No `d_rvalid`. The next grant is possible at T+1.
- Read grant:
  - MEM_LATENCY = 1: go directly to RESP.
  - MEM_LATENCY > 1: go to WAIT with the counter loaded to MEM_LATENCY-1, decrementing each cycle; enter RESP when it reaches 1.
  - Latch the requester identity (`owner`) at grant.
- RESP (cycle T+MEM_LATENCY):
  - Pulse `d_rvalid` or `if_rvalid` according to `owner`.
  - rdata outputs pass `mem_rdata` combinationally; they are 0 when the corresponding rvalid is low.
  - Next state is IDLE. No grant is issued in RESP; the next grant is possible at T+MEM_LATENCY+1.
- Flush:
  - `if_flush` high in any cycle from T through T+MEM_LATENCY while `owner` = fetch sets a sticky `squash` flag.
  - In RESP with `squash` set, `if_rvalid` stays 0.
  - `squash` clears on entry to IDLE.
  - `if_flush` in IDLE blocks `if_gnt` that cycle.
- Starvation counter (saturating, 4-bit):
  - Increment on a `d_gnt` while `if_req` = 1.
  - Clear on `if_gnt`, or in any IDLE cycle with `if_req` = 0.
- The arbiter performs no address alignment or range checking.

## Timing
- Reset (reset = 0, asynchronous):
  - State = IDLE; counter = 0; `starve_cnt` = 0; `owner` = data; `squash` = 0.
  - All outputs 0, including `busy`.
- Reset asserted mid-read aborts the transaction; no rvalid is ever produced for it.
- Grants are combinational from requests in IDLE. Requesters sample `gnt` at the clock edge and may drop or replace the request on the following cycle.
- Load/fetch latency: grant at T, rvalid at T+MEM_LATENCY, exactly one cycle wide.
- Throughput:
  - One read every MEM_LATENCY+1 cycles.
  - One store per cycle.
- `busy` = 1 in WAIT and RESP.

## Test plan
- Single fetch: MEM_LATENCY=2, `if_req` at cycle 0 with `if_addr`=0x2000 and memory word 0x8800_0000 → `if_gnt`@0, `mem_en`@0, `mem_addr`=0x2000, `if_rvalid`@2, `if_rdata`=0x8800_0000, `busy`@1–2.
- Contention: `if_req` and `d_req` (load, 0x1000) both at cycle 0 → `d_gnt`@0, `d_rvalid`@2, `if_gnt`@3, `if_rvalid`@5.
- Starvation: STARVE_LIMIT=4, back-to-back stores plus `if_req` held → 4 `d_gnt`s at cycles 0–3, then `if_gnt`@4, then `d_gnt` resumes @5+MEM_LATENCY.
- Store: `d_we`=1, `d_addr`=0x80000, `d_wdata`=0xDEAD_BEEF → `mem_we`=`mem_en`=1 @0, no `d_rvalid`, a second store is granted @1.
- Flush: fetch granted @0, `if_flush` pulsed @1 → `if_rvalid` stays 0 @2, next grant possible @3.
- Reset mid-read: load granted @0, reset=0 @1 → all outputs 0 immediately, no `d_rvalid`; after reset=1, a fetch is granted on its first request.
